// File: rtl/knn_ctrl.sv
// Batch sequencer for the knn solver core: loads test points into the solver bank,
// streams the dataset through the core, then drains HW_K ranked results per solver.
module knn_ctrl #(
   parameter int unsigned HW_K      = 10,
   parameter int unsigned N_SOLVERS = 4,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned POINT_W   = 32,
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_start,
   input  logic                         cfg_abort,
   input  logic [CNT_W-1:0]             cfg_n_test,
   input  logic [CNT_W-1:0]             cfg_n_data,
   input  logic [ADDR_W-1:0]            cfg_test_base,
   input  logic [ADDR_W-1:0]            cfg_data_base,
   output logic                         busy,
   output logic                         done,
   output logic                         mem_req,
   output logic [ADDR_W-1:0]            mem_addr,
   input  logic                         mem_ack,
   input  logic [POINT_W-1:0]           mem_rdata,
   output logic                         knn_rst,
   output logic                         knn_valid,
   output logic [N_SOLVERS*POINT_W-1:0] knn_data_1,
   output logic [POINT_W-1:0]           knn_data_2,
   output logic                         knn_done,
   output logic [15:0]                  knn_sel,
   output logic [15:0]                  knn_solver_sel,
   input  logic [DATA_W-1:0]            knn_data_out,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [DATA_W-1:0]            res_data,
   output logic [CNT_W-1:0]             res_test_idx,
   output logic [15:0]                  res_rank,
   output logic                         res_last
);

   typedef enum logic [2:0] {StIdle, StLoad, StClr, StStream, StDrain, StFinish} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    n_test_q, n_test_d;
   logic [CNT_W-1:0]    n_data_q, n_data_d;
   logic [ADDR_W-1:0]   test_base_q, test_base_d;
   logic [ADDR_W-1:0]   data_base_q, data_base_d;
   logic [CNT_W-1:0]    t_base_q, t_base_d;
   logic [CNT_W-1:0]    batch_q, batch_d;
   logic [CNT_W-1:0]    slot_q, slot_d;
   logic [CNT_W-1:0]    d_idx_q, d_idx_d;
   logic                req_q, req_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [POINT_W-1:0]  slot_data_q [N_SOLVERS];
   logic [POINT_W-1:0]  slot_data_d [N_SOLVERS];
   logic [POINT_W-1:0]  data_2_q, data_2_d;
   logic                valid_q, valid_d;
   logic                clr_q, clr_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [15:0]         sel_q, sel_d;
   logic [15:0]         ssel_q, ssel_d;

   logic [CNT_W:0]      base_next;
   logic                ssel_last;
   logic                sel_last;

   assign base_next = {1'b0, t_base_q} + {1'b0, batch_q};
   assign ssel_last = (ssel_q == 16'(batch_q - CNT_W'(1)));
   assign sel_last  = (sel_q == 16'(HW_K - 1));

   function automatic logic [CNT_W-1:0] batch_size(input logic [CNT_W-1:0] rem);
      if (rem >= CNT_W'(N_SOLVERS)) return CNT_W'(N_SOLVERS);
      return rem;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         n_test_q    <= '0;
         n_data_q    <= '0;
         test_base_q <= '0;
         data_base_q <= '0;
         t_base_q    <= '0;
         batch_q     <= '0;
         slot_q      <= '0;
         d_idx_q     <= '0;
         req_q       <= 1'b0;
         addr_q      <= '0;
         slot_data_q <= '{default: '0};
         data_2_q    <= '0;
         valid_q     <= 1'b0;
         clr_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sel_q       <= '0;
         ssel_q      <= '0;
      end else begin
         state_q     <= state_d;
         n_test_q    <= n_test_d;
         n_data_q    <= n_data_d;
         test_base_q <= test_base_d;
         data_base_q <= data_base_d;
         t_base_q    <= t_base_d;
         batch_q     <= batch_d;
         slot_q      <= slot_d;
         d_idx_q     <= d_idx_d;
         req_q       <= req_d;
         addr_q      <= addr_d;
         slot_data_q <= slot_data_d;
         data_2_q    <= data_2_d;
         valid_q     <= valid_d;
         clr_q       <= clr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         sel_q       <= sel_d;
         ssel_q      <= ssel_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      n_test_d    = n_test_q;
      n_data_d    = n_data_q;
      test_base_d = test_base_q;
      data_base_d = data_base_q;
      t_base_d    = t_base_q;
      batch_d     = batch_q;
      slot_d      = slot_q;
      d_idx_d     = d_idx_q;
      req_d       = req_q;
      addr_d      = addr_q;
      slot_data_d = slot_data_q;
      data_2_d    = data_2_q;
      valid_d     = 1'b0;
      clr_d       = 1'b0;
      busy_d      = busy_q;
      done_d      = done_q;
      sel_d       = sel_q;
      ssel_d      = ssel_q;

      case (state_q)
         StIdle: begin
            if (cfg_start && !cfg_abort) begin
               n_test_d    = cfg_n_test;
               n_data_d    = cfg_n_data;
               test_base_d = cfg_test_base;
               data_base_d = cfg_data_base;
               t_base_d    = '0;
               sel_d       = '0;
               ssel_d      = '0;
               done_d      = 1'b0;
               busy_d      = 1'b1;
               if (cfg_n_test == '0 || cfg_n_data == '0) begin
                  state_d = StFinish;
               end else begin
                  state_d     = StLoad;
                  batch_d     = batch_size(cfg_n_test);
                  slot_d      = '0;
                  slot_data_d = '{default: '0};
               end
            end
         end
         StLoad: begin
            if (req_q) begin
               if (mem_ack) begin
                  req_d = 1'b0;
                  for (int s = 0; s < N_SOLVERS; s++) begin
                     if (slot_q == CNT_W'(s)) slot_data_d[s] = mem_rdata;
                  end
                  slot_d = slot_q + CNT_W'(1);
                  if (slot_q + CNT_W'(1) == batch_q) begin
                     state_d = StClr;
                     clr_d   = 1'b1;
                  end
               end
            end else if (slot_q < batch_q) begin
               req_d  = 1'b1;
               addr_d = test_base_q + ADDR_W'(t_base_q + slot_q);
            end
         end
         StClr: begin
            state_d = StStream;
            d_idx_d = '0;
         end
         StStream: begin
            // A strobe follows each ack; the state advances only after the final strobe.
            if (req_q) begin
               if (mem_ack) begin
                  req_d    = 1'b0;
                  data_2_d = mem_rdata;
                  valid_d  = 1'b1;
                  d_idx_d  = d_idx_q + CNT_W'(1);
               end
            end else if (d_idx_q < n_data_q) begin
               req_d  = 1'b1;
               addr_d = data_base_q + ADDR_W'(d_idx_q);
            end else if (valid_q) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (res_ready) begin
               if (sel_last) begin
                  sel_d = '0;
                  if (ssel_last) begin
                     ssel_d   = '0;
                     t_base_d = base_next[CNT_W-1:0];
                     if (base_next < {1'b0, n_test_q}) begin
                        state_d     = StLoad;
                        batch_d     = batch_size(n_test_q - base_next[CNT_W-1:0]);
                        slot_d      = '0;
                        slot_data_d = '{default: '0};
                     end else begin
                        state_d = StFinish;
                     end
                  end else begin
                     ssel_d = ssel_q + 16'd1;
                  end
               end else begin
                  sel_d = sel_q + 16'd1;
               end
            end
         end
         StFinish: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (cfg_abort && state_q != StIdle) begin
         state_d = StIdle;
         req_d   = 1'b0;
         valid_d = 1'b0;
         clr_d   = 1'b1;
         busy_d  = 1'b0;
         done_d  = done_q;
         sel_d   = '0;
         ssel_d  = '0;
      end
   end

   always_comb begin
      busy       = busy_q;
      done       = done_q;
      mem_req    = req_q;
      mem_addr   = addr_q;
      knn_rst    = clr_q;
      knn_valid  = valid_q;
      knn_data_1 = '0;
      for (int s = 0; s < N_SOLVERS; s++) begin
         knn_data_1[s*POINT_W +: POINT_W] = slot_data_q[s];
      end
      knn_data_2     = data_2_q;
      knn_done       = (state_q == StDrain);
      knn_sel        = sel_q;
      knn_solver_sel = ssel_q;
      res_valid      = (state_q == StDrain);
      res_data       = knn_data_out;
      res_test_idx   = t_base_q + CNT_W'(ssel_q);
      res_rank       = sel_q;
      res_last       = (state_q == StDrain) && sel_last && ssel_last &&
                       (base_next == {1'b0, n_test_q});
   end

endmodule
